lcd_text_console: RTL and testbench

- Character-stream terminal front end for the 60x17-cell text LCD controller.
- Accepts one byte per handshake and tracks the cursor. Handles the control codes CR, LF, BS and FF.
- Converts each accepted byte into byte-wide MMIO writes into the LCD text VRAM. Cell layout in VRAM: even address = ASCII code, odd address = attribute.
- Sits between the CPU/UART character port and the LCD MMIO write port. The screen wraps to row 0 rather than scrolling, because VRAM is write-only.

---
 rtl/lcd_text_console.sv | 257 +++++++++++++++++++++++++
 tb/tb_lcd_text_console.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_console.sv
// ============================================================================
// Module   : lcd_text_console
// Brief    : Character-stream terminal front end for the text LCD. Accepts
//            one byte per handshake, tracks the cursor, handles CR/LF/BS/FF
//            and turns every accepted byte into byte-wide MMIO writes into
//            the LCD text VRAM (even address = ASCII, odd = attribute).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MMIO_ADDR_LCD
`define MMIO_ADDR_LCD 16'h8000
`endif

module lcd_text_console #(
    parameter logic [15:0] MMIO_BASE    = `MMIO_ADDR_LCD,
    parameter int          COLS         = 60,
    parameter int          ROWS         = 17,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr_data,
    input  logic        attr_we,
    output logic [15:0] mmio_addr,
    output logic [7:0]  mmio_data,
    output logic        mmio_req,
    input  logic        mmio_done,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [5:0] c_last_col      = 6'(COLS - 1);
    localparam logic [9:0] c_last_col_idx  = 10'(COLS - 1);
    localparam logic [4:0] c_last_row      = 5'(ROWS - 1);
    localparam logic [9:0] c_last_cell     = 10'(COLS * ROWS - 1);
    localparam logic [9:0] c_cols          = 10'(COLS);
    localparam logic [7:0] c_space         = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DECODE     = 3'd1,
        S_WR_LO      = 3'd2,
        S_WR_HI      = 3'd3,
        S_CLR_ROW    = 3'd4,
        S_CLR_SCREEN = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_char;       // latched input byte (space for a backspace erase)
    logic [7:0]  r_attr;
    logic [5:0]  r_col;
    logic [4:0]  r_row;
    logic [9:0]  r_cnt;        // cell counter during row / screen clears
    logic        r_half;       // 0 = ASCII byte, 1 = attribute byte of a clear cell
    logic        r_adv;        // cell write advances the cursor (printable, not BS)
    logic        r_req;
    logic [15:0] r_addr;
    logic [7:0]  r_data;

    logic [9:0]  w_row_base;
    logic [9:0]  w_cell;
    logic        w_half;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_wr_state;
    logic        w_issue;
    logic        w_ack;
    logic [4:0]  w_next_row;

    assign w_row_base = 10'(r_row) * c_cols;
    assign w_next_row = (r_row == c_last_row) ? 5'd0 : r_row + 5'd1;
    assign w_wr_state = (r_state == S_WR_LO) || (r_state == S_WR_HI) ||
                        (r_state == S_CLR_ROW) || (r_state == S_CLR_SCREEN);
    // A write is launched in the first cycle of a write step with req low;
    // the one-cycle low gap after each acknowledge falls out of this.
    assign w_issue    = w_wr_state && !r_req;
    assign w_ack      = r_req && mmio_done;
    assign w_addr     = MMIO_BASE + {5'd0, w_cell, w_half};

    // Select the target cell, byte half and write data for the current step
    always_comb begin
        w_cell  = w_row_base + {4'd0, r_col};
        w_half  = 1'b0;
        w_wdata = r_char;
        case (r_state)
            S_WR_LO: begin
                w_half  = 1'b0;
                w_wdata = r_char;
            end
            S_WR_HI: begin
                w_half  = 1'b1;
                w_wdata = r_attr;
            end
            S_CLR_ROW: begin
                w_cell  = w_row_base + r_cnt;
                w_half  = r_half;
                w_wdata = r_half ? r_attr : c_space;
            end
            S_CLR_SCREEN: begin
                w_cell  = r_cnt;
                w_half  = r_half;
                w_wdata = r_half ? r_attr : c_space;
            end
            default: begin
                w_cell  = w_row_base + {4'd0, r_col};
                w_half  = 1'b0;
                w_wdata = r_char;
            end
        endcase
    end

    // Console state machine, cursor tracking and MMIO write handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLR_SCREEN;
            r_char  <= 8'd0;
            r_attr  <= DEFAULT_ATTR;
            r_col   <= 6'd0;
            r_row   <= 5'd0;
            r_cnt   <= 10'd0;
            r_half  <= 1'b0;
            r_adv   <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= 16'd0;
            r_data  <= 8'd0;
        end else begin
            if (attr_we) begin
                r_attr <= attr_data;
            end

            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_addr;
                r_data <= w_wdata;
            end else if (w_ack) begin
                r_req  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_char  <= in_data;
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    r_adv <= 1'b0;
                    if (r_char >= 8'h20 && r_char <= 8'h7E) begin
                        r_adv   <= 1'b1;
                        r_state <= S_WR_LO;
                    end else begin
                        case (r_char)
                            8'h0D: begin
                                r_col   <= 6'd0;
                                r_state <= S_IDLE;
                            end
                            8'h0A: begin
                                r_col   <= 6'd0;
                                r_row   <= w_next_row;
                                r_cnt   <= 10'd0;
                                r_half  <= 1'b0;
                                r_state <= S_CLR_ROW;
                            end
                            8'h08: begin
                                // Backspace never wraps to the previous row
                                if (r_col != 6'd0) begin
                                    r_col   <= r_col - 6'd1;
                                    r_char  <= c_space;
                                    r_state <= S_WR_LO;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                            8'h0C: begin
                                r_cnt   <= 10'd0;
                                r_half  <= 1'b0;
                                r_state <= S_CLR_SCREEN;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end

                S_WR_LO: begin
                    if (w_ack) begin
                        r_state <= S_WR_HI;
                    end
                end

                S_WR_HI: begin
                    if (w_ack) begin
                        if (!r_adv) begin
                            r_state <= S_IDLE;
                        end else if (r_col == c_last_col) begin
                            // Wrap: new line, which wipes the row it lands on
                            r_col   <= 6'd0;
                            r_row   <= w_next_row;
                            r_cnt   <= 10'd0;
                            r_half  <= 1'b0;
                            r_state <= S_CLR_ROW;
                        end else begin
                            r_col   <= r_col + 6'd1;
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_CLR_ROW: begin
                    if (w_ack) begin
                        r_half <= ~r_half;
                        if (r_half) begin
                            if (r_cnt == c_last_col_idx) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                    end
                end

                S_CLR_SCREEN: begin
                    if (w_ack) begin
                        r_half <= ~r_half;
                        if (r_half) begin
                            if (r_cnt == c_last_cell) begin
                                r_col   <= 6'd0;
                                r_row   <= 5'd0;
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mmio_req   = r_req;
    assign mmio_addr  = r_addr;
    assign mmio_data  = r_data;
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_console.sv
// ============================================================================
// Module   : tb_lcd_text_console
// Brief    : Self-checking bench for lcd_text_console. A behavioural console
//            model pushes expected VRAM writes into a scoreboard queue; an
//            LCD responder acknowledges writes and pops/compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_text_console;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  attr_data = 8'd0;
    logic        attr_we = 1'b0;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_data;
    logic        mmio_req;
    logic        mmio_done = 1'b0;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    always #5 clock = ~clock;

    lcd_text_console #(
        .MMIO_BASE    (16'h1000),
        .COLS         (60),
        .ROWS         (17),
        .DEFAULT_ATTR (8'h0F)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .attr_data  (attr_data),
        .attr_we    (attr_we),
        .mmio_addr  (mmio_addr),
        .mmio_data  (mmio_data),
        .mmio_req   (mmio_req),
        .mmio_done  (mmio_done),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [23:0] sb[$];          // expected {addr, data} in write order
    int          lcd_delay = 1;  // cycles of req before the LCD acks
    int          wcnt = 0;
    int          req_run = 0;
    int          low_run = 0;
    bit          gap_skip = 1'b1;
    int          last_len = 0;
    bit          prev_req = 1'b0;
    logic [15:0] prev_addr = 16'd0;
    logic [7:0]  prev_data = 8'd0;

    int          m_col = 0;
    int          m_row = 0;
    logic [7:0]  m_attr = 8'h0F;

    // LCD responder plus scoreboard: ack after lcd_delay cycles, compare each write
    always @(negedge clock) begin
        logic [23:0] exp_w;
        if (reset) begin
            mmio_done = 1'b0;
            wcnt      = 0;
            req_run   = 0;
            low_run   = 0;
            gap_skip  = 1'b1;
            prev_req  = 1'b0;
        end else begin
            if (mmio_req) begin
                if (prev_req) begin
                    total++;
                    if (mmio_addr !== prev_addr || mmio_data !== prev_data) begin
                        bad++;
                        $display("FAIL req_stable addr=%h data=%h required addr=%h data=%h",
                                 mmio_addr, mmio_data, prev_addr, prev_data);
                    end
                end
                if (low_run > 0 && !gap_skip) begin
                    total++;
                    if (low_run != 1) begin
                        bad++;
                        $display("FAIL req_gap low_cycles=%0d required=1", low_run);
                    end
                end
                low_run  = 0;
                gap_skip = 1'b0;
                req_run++;
            end else begin
                low_run++;
                req_run = 0;
                if (!busy) gap_skip = 1'b1;
            end

            if (mmio_done) begin
                mmio_done = 1'b0;
                wcnt      = 0;
            end else if (mmio_req) begin
                if (wcnt >= lcd_delay) begin
                    mmio_done = 1'b1;
                    last_len  = req_run;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write addr=%h data=%h required=none",
                                 mmio_addr, mmio_data);
                    end else begin
                        exp_w = sb.pop_front();
                        if ({mmio_addr, mmio_data} !== exp_w) begin
                            bad++;
                            $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                                     mmio_addr, mmio_data, exp_w[23:8], exp_w[7:0]);
                        end
                    end
                end else begin
                    wcnt++;
                end
            end
            prev_req  = mmio_req;
            prev_addr = mmio_addr;
            prev_data = mmio_data;
        end
    end

    task automatic push_cell(input int idx, input logic [7:0] ch, input logic [7:0] at);
        sb.push_back({16'h1000 + 16'(2 * idx), ch});
        sb.push_back({16'h1000 + 16'(2 * idx + 1), at});
    endtask

    task automatic model_advance();
        m_col = 0;
        m_row = (m_row == 16) ? 0 : m_row + 1;
        for (int c = 0; c < 60; c++) push_cell(m_row * 60 + c, 8'h20, m_attr);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_cell(m_row * 60 + m_col, b, m_attr);
            m_col++;
            if (m_col == 60) model_advance();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            model_advance();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_cell(m_row * 60 + m_col, 8'h20, m_attr);
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 1020; i++) push_cell(i, 8'h20, m_attr);
            m_col = 0;
            m_row = 0;
        end
    endtask

    // Offer one byte (optionally with a same-cycle attribute load); starts and ends on a negedge
    task automatic send_byte(input logic [7:0] b, input bit with_attr, input logic [7:0] at);
        int t = 0;
        while (!in_ready && t < 20000) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout in_ready=%0d required=1", in_ready);
        end
        if (with_attr) m_attr = at;
        model_byte(b);
        in_data   = b;
        in_valid  = 1'b1;
        attr_we   = with_attr;
        attr_data = at;
        @(negedge clock);
        in_valid  = 1'b0;
        attr_we   = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while ((busy || sb.size() != 0) && t < 20000) begin
            @(negedge clock);
            t++;
        end
        ok = !busy && (sb.size() == 0);
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (mmio_req !== 1'b0 || mmio_addr !== 16'd0 || mmio_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_mmio req=%0d addr=%h data=%h required 0/0000/00", mmio_req, mmio_addr, mmio_data);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags in_ready=%0d busy=%0d required 0/1", in_ready, busy);
        end
        total++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL reset_cursor col=%0d row=%0d required 0/0", cursor_col, cursor_row);
        end
        for (int i = 0; i < 1020; i++) push_cell(i, 8'h20, 8'h0F);
        reset = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL powerup_clear pending=%0d busy=%0d required 0/0", sb.size(), busy);
        end
        total++;
        if (in_ready !== 1'b1 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL powerup_done in_ready=%0d col=%0d row=%0d required 1/0/0", in_ready, cursor_col, cursor_row);
        end
    endtask

    task automatic test_printable();
        bit ok;
        send_byte(8'h41, 1'b0, 8'h00);
        send_byte(8'h42, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL printable ok=%0d col=%0d row=%0d required 1/2/0", ok, cursor_col, cursor_row);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        send_byte(8'h0D, 1'b0, 8'h00);
        for (int i = 0; i < 60; i++) send_byte(8'h61 + 8'(i % 26), 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd0 || cursor_row !== 5'd1) begin
            bad++;
            $display("FAIL wrap ok=%0d col=%0d row=%0d required 1/0/1", ok, cursor_col, cursor_row);
        end
        send_byte(8'h5A, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd1 || cursor_row !== 5'd1) begin
            bad++;
            $display("FAIL after_wrap ok=%0d col=%0d row=%0d required 1/1/1", ok, cursor_col, cursor_row);
        end
    endtask

    task automatic test_control();
        bit ok;
        bit seen_req;
        for (int i = 0; i < 15; i++) send_byte(8'h0A, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd0 || cursor_row !== 5'd16) begin
            bad++;
            $display("FAIL lf_to_16 ok=%0d col=%0d row=%0d required 1/0/16", ok, cursor_col, cursor_row);
        end
        send_byte(8'h0A, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL lf_row_wrap ok=%0d col=%0d row=%0d required 1/0/0", ok, cursor_col, cursor_row);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b0, 8'h00);
        wait_idle(ok);
        seen_req = 1'b0;
        send_byte(8'h0D, 1'b0, 8'h00);
        repeat (6) begin
            if (mmio_req) seen_req = 1'b1;
            @(negedge clock);
        end
        total++;
        if (seen_req || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL cr req_seen=%0d col=%0d row=%0d required 0/0/0", seen_req, cursor_col, cursor_row);
        end
        send_byte(8'h08, 1'b0, 8'h00);
        repeat (6) begin
            if (mmio_req) seen_req = 1'b1;
            @(negedge clock);
        end
        total++;
        if (seen_req || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL bs_col0 req_seen=%0d col=%0d row=%0d required 0/0/0", seen_req, cursor_col, cursor_row);
        end
        for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), 1'b0, 8'h00);
        send_byte(8'h08, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL bs_col3 ok=%0d col=%0d row=%0d required 1/2/0", ok, cursor_col, cursor_row);
        end
    endtask

    task automatic test_attr();
        bit ok;
        attr_data = 8'h1E;
        attr_we   = 1'b1;
        m_attr    = 8'h1E;
        @(negedge clock);
        attr_we   = 1'b0;
        send_byte(8'h78, 1'b0, 8'h00);
        send_byte(8'h79, 1'b1, 8'h2A);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd4 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL attr ok=%0d col=%0d row=%0d required 1/4/0", ok, cursor_col, cursor_row);
        end
        send_byte(8'h07, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd4 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL drop_bel ok=%0d col=%0d row=%0d required 1/4/0", ok, cursor_col, cursor_row);
        end
    endtask

    task automatic test_slow_and_reset();
        bit ok;
        lcd_delay = 10;
        send_byte(8'h71, 1'b0, 8'h00);
        wait_idle(ok);
        total++;
        if (!ok || last_len != 11) begin
            bad++;
            $display("FAIL slow_lcd ok=%0d req_cycles=%0d required 1/11", ok, last_len);
        end
        lcd_delay = 1;
        send_byte(8'h0C, 1'b0, 8'h00);
        repeat (60) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (mmio_req !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_clear req=%0d busy=%0d required 0/1", mmio_req, busy);
        end
        sb.delete();
        m_col  = 0;
        m_row  = 0;
        m_attr = 8'h0F;
        for (int i = 0; i < 1020; i++) push_cell(i, 8'h20, 8'h0F);
        reset = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok || cursor_col !== 6'd0 || cursor_row !== 5'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_restart ok=%0d col=%0d row=%0d ready=%0d required 1/0/0/1",
                     ok, cursor_col, cursor_row, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_printable();
        test_wrap();
        test_control();
        test_attr();
        test_slow_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
